position_input_decoder: RTL

- Front end for the rider-position inputs: drops, hoods, tops, bar and seat switches.
- Synchronises and debounces the five raw switches, then encodes the hand position into a 3-bit code.
- Delivers position-change events to a downstream consumer over a valid/ready handshake. The consumer is the LED/buzzer output logic.
- Flags illegal multi-grip combinations and counts events the consumer collapsed by stalling.

---
 rtl/position_input_decoder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/position_input_decoder.sv
// Rider-position front end: synchronise, debounce and encode five switches and emit
// position-change events over valid/ready. Optional macro SEAT_TIMEOUT_EN adds seat_alarm.
module position_input_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int STAND_CYCLES    = 150000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       drops_button,
  input  logic       hoods_button,
  input  logic       tops_button,
  input  logic       bar_button,
  input  logic       seat_button,
  output logic [3:0] pos_data,
  output logic       pos_valid,
  input  logic       pos_ready,
  output logic       fault,
  output logic [7:0] overrun_cnt,
  output logic       seat_alarm
);

  if ((DEBOUNCE_CYCLES < 1) || (DEBOUNCE_CYCLES > (2 ** CNT_W))) begin : g_bad_debounce
    $error("CNT_W too narrow for DEBOUNCE_CYCLES");
  end
  if ((STAND_CYCLES < 1) || (STAND_CYCLES > (2 ** 28))) begin : g_bad_stand
    $error("STAND_CYCLES must fit the 28-bit stand counter");
  end

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Bit order: 0 drops, 1 hoods, 2 tops, 3 bar, 4 seat.
  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] db;

  assign raw = {seat_button, bar_button, tops_button, hoods_button, drops_button};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < 5; i++) begin : g_debounce
    logic [CNT_W-1:0] cnt;
    logic             db_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        db_q <= 1'b0;
      end else if (sync2[i] == db_q) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        cnt  <= '0;
        db_q <= ~db_q;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end

    assign db[i] = db_q;
  end

  logic [2:0] code_c;
  logic       fault_c;

  always_comb begin
    code_c  = 3'd0;
    fault_c = 1'b0;
    case (db[3:0])
      4'b0000: code_c = 3'd0;
      4'b0001: code_c = 3'd1;
      4'b0010: code_c = 3'd2;
      4'b0100: code_c = 3'd3;
      4'b1000: code_c = 3'd4;
      default: begin
        code_c  = 3'd7;
        fault_c = 1'b1;
      end
    endcase
  end

  logic [3:0] cur_next;
  logic [3:0] cur;
  logic       fault_q;
  logic       cur_chg;

  assign cur_next = {db[4], code_c};
  assign cur_chg  = (cur_next != cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur     <= '0;
      fault_q <= 1'b0;
    end else begin
      cur     <= cur_next;
      fault_q <= fault_c;
    end
  end

  assign fault = fault_q;

  // Handshake: an event transfers on a cycle where pos_valid && pos_ready at the rising
  // edge; while pos_valid is high pos_data is held stable, pos_ready is ignored when
  // pos_valid is low, and pos_valid is a pure register output (no path from pos_ready).
  state_t     state;
  state_t     state_next;
  logic       load;
  logic [3:0] sent;
  logic       collapse;

  always_comb begin
    state_next = state;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (cur != sent) begin
          load       = 1'b1;
          state_next = PEND;
        end
      end
      PEND: begin
        if (pos_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  assign pos_valid = (state == PEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_data <= '0;
      sent     <= '0;
    end else if (load) begin
      pos_data <= cur;
      sent     <= cur;
    end
  end

  // A change while stalled is collapsed; one accepted on the same edge is still delivered.
  assign collapse = (state == PEND) && !pos_ready && cur_chg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             overrun_cnt <= '0;
    else if (collapse && overrun_cnt != 8'hFF) overrun_cnt <= overrun_cnt + 8'd1;
  end

`ifdef SEAT_TIMEOUT_EN
  localparam logic [27:0] STAND_LAST = 28'(STAND_CYCLES - 1);
  logic [27:0] stand_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       stand_cnt <= '0;
    else if (db[4])                   stand_cnt <= '0;
    else if (stand_cnt != STAND_LAST) stand_cnt <= stand_cnt + 28'd1;
  end

  assign seat_alarm = (stand_cnt == STAND_LAST);
`else
  assign seat_alarm = 1'b0;
`endif

endmodule
